// File: rtl/float_op_sequencer.sv
// Pulls operand vectors from a loader, issues them to a fixed-latency float operator
// and pairs returned results with their vector IDs, in issue order, for a result checker.
module float_op_sequencer #(
    parameter int pPrecision = 2,
    parameter int pWidthExp  = 8,
    parameter int pWidthMan  = 23,
    parameter int pDepth     = 8,
    localparam int pExpW = (pPrecision == 1) ? 8  : (pPrecision == 2) ? 11 : pWidthExp,
    localparam int pManW = (pPrecision == 1) ? 23 : (pPrecision == 2) ? 52 : pWidthMan,
    localparam int W     = pExpW + pManW + 1
) (
    input  logic         i_Clk,
    input  logic         i_ARstN,
    input  logic         i_Start,
    output logic         o_LdEn,
    input  logic         i_LdEoF,
    input  logic [31:0]  iv_LdID,
    input  logic [W-1:0] iv_LdA,
    input  logic [W-1:0] iv_LdB,
    input  logic [W-1:0] iv_LdC,
    output logic         o_OpValid,
    output logic [W-1:0] ov_OpA,
    output logic [W-1:0] ov_OpB,
    output logic [W-1:0] ov_OpC,
    input  logic         i_ResValid,
    input  logic [W-1:0] iv_Res,
    output logic         o_OutValid,
    input  logic         i_OutReady,
    output logic [31:0]  ov_OutID,
    output logic [W-1:0] ov_OutRes,
    output logic         o_Busy,
    output logic         o_Done,
    output logic         o_Err,
    output logic [31:0]  ov_IssueCnt,
    output logic [31:0]  ov_RetireCnt
);

    localparam int AW = (pDepth > 1) ? $clog2(pDepth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(pDepth);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        rState, wNextState;
    logic [CW-1:0] rCred, wCredNext;
    logic          rLdPend;
    logic          wStartRun, wIssue, wEofDisc, wHs, wResRoom, wResPush, wResErr;

    logic [31:0]   rIdMem  [pDepth];
    logic [W-1:0]  rResMem [pDepth];
    logic [AW-1:0] rIdWr, rIdRd, rResWr, rResRd;
    logic [CW-1:0] rIdCnt, rResCnt;

    assign wStartRun  = i_Start && ((rState == IDLE) || (rState == DONE));
    assign wIssue     = rLdPend && !i_LdEoF;
    assign wEofDisc   = rLdPend && i_LdEoF;
    assign o_LdEn     = (rState == RUN) && (rCred < DEPTH_C) && !wEofDisc;
    assign o_OutValid = (rResCnt != '0);
    assign wHs        = o_OutValid && i_OutReady;
    // A result is only legal if some issued ID is still waiting for its partner.
    assign wResRoom   = (rResCnt < rIdCnt);
    assign wResPush   = i_ResValid && wResRoom;
    assign wResErr    = i_ResValid && !wResRoom;
    assign wCredNext  = rCred + CW'(o_LdEn) - CW'(wHs) - CW'(wEofDisc);

    assign ov_OutID  = o_OutValid ? rIdMem[rIdRd]   : '0;
    assign ov_OutRes = o_OutValid ? rResMem[rResRd] : '0;
    assign o_Busy    = (rState == RUN) || (rState == DRAIN);
    assign o_Done    = (rState == DONE);

    // Looking at the next credit value lets DONE rise the cycle after the last retire.
    always_comb begin
        wNextState = rState;
        case (rState)
            IDLE, DONE: if (i_Start) wNextState = RUN;
            RUN:        if (wEofDisc) wNextState = (wCredNext == '0) ? DONE : DRAIN;
            DRAIN:      if ((wCredNext == '0) && !rLdPend) wNextState = DONE;
            default:    wNextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            rState       <= IDLE;
            rCred        <= '0;
            rLdPend      <= 1'b0;
            o_Err        <= 1'b0;
            ov_IssueCnt  <= '0;
            ov_RetireCnt <= '0;
        end else begin
            rState  <= wNextState;
            rLdPend <= o_LdEn;
            if (wStartRun) begin
                rCred        <= '0;
                o_Err        <= 1'b0;
                ov_IssueCnt  <= '0;
                ov_RetireCnt <= '0;
            end else begin
                rCred <= wCredNext;
                if (wResErr) o_Err <= 1'b1;
                if (wIssue)  ov_IssueCnt  <= ov_IssueCnt + 32'd1;
                if (wHs)     ov_RetireCnt <= ov_RetireCnt + 32'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            o_OpValid <= 1'b0;
            ov_OpA    <= '0;
            ov_OpB    <= '0;
            ov_OpC    <= '0;
        end else begin
            o_OpValid <= wIssue;
            if (wIssue) begin
                ov_OpA <= iv_LdA;
                ov_OpB <= iv_LdB;
                ov_OpC <= iv_LdC;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            rIdWr   <= '0;
            rIdRd   <= '0;
            rResWr  <= '0;
            rResRd  <= '0;
            rIdCnt  <= '0;
            rResCnt <= '0;
        end else if (wStartRun) begin
            rIdWr   <= '0;
            rIdRd   <= '0;
            rResWr  <= '0;
            rResRd  <= '0;
            rIdCnt  <= '0;
            rResCnt <= '0;
        end else begin
            if (wIssue)   rIdWr  <= rIdWr + AW'(1);
            if (wResPush) rResWr <= rResWr + AW'(1);
            if (wHs) begin
                rIdRd  <= rIdRd + AW'(1);
                rResRd <= rResRd + AW'(1);
            end
            rIdCnt  <= rIdCnt + CW'(wIssue) - CW'(wHs);
            rResCnt <= rResCnt + CW'(wResPush) - CW'(wHs);
        end
    end

    // Storage needs no reset; the counts above decide what is visible.
    always_ff @(posedge i_Clk) begin
        if (wIssue)   rIdMem[rIdWr]   <= iv_LdID;
        if (wResPush) rResMem[rResWr] <= iv_Res;
    end

endmodule
